// File: rtl/video_capture_pkg.sv
// Shared types for the video capture path: capture FSM states, sync-pulse
// classification codes and the byte-address helper.
`timescale 1ns/1ps
package video_capture_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_VSYNC = 3'd0,
    ST_VPORCH     = 3'd1,
    ST_WAIT_LINE  = 3'd2,
    ST_BACKPORCH  = 3'd3,
    ST_ACTIVE     = 3'd4
  } cap_state_e;

  typedef enum logic [1:0] {
    SYNC_NONE  = 2'd0,
    SYNC_HSYNC = 2'd1,
    SYNC_VSYNC = 2'd2
  } sync_class_e;

  function automatic int unsigned byte_addr(input int unsigned line,
                                            input int unsigned byte_idx,
                                            input int unsigned bytes_per_line);
    return line * bytes_per_line + byte_idx;
  endfunction

endpackage

// File: rtl/video_sync_classifier.sv
// Registers the raw sync/pixel inputs, measures sync-high width and emits
// one-clock rise / classified-fall pulses aligned with a delayed pixel bit.
`timescale 1ns/1ps
module video_sync_classifier
  import video_capture_pkg::*;
#(
  parameter int unsigned VSYNC_MIN = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        sync_i,
  input  logic        pix_i,
  output sync_class_e fall_class_o,
  output logic        rise_o,
  output logic        pix_o
);

  localparam int unsigned CW = $clog2(VSYNC_MIN + 1);
  localparam logic [CW-1:0] WIDTH_SAT = CW'(VSYNC_MIN);

  logic          sync_q, sync_prev_q, pix_q, pix_dly_q, rise_q, rise_d;
  logic [CW-1:0] width_q, width_d;
  sync_class_e   fall_class_q, fall_class_d;

  // Width counter saturates so an arbitrarily long pulse still reads as vsync.
  always_comb begin
    width_d      = width_q;
    fall_class_d = SYNC_NONE;
    rise_d       = sync_q && !sync_prev_q;
    if (sync_q) begin
      if (width_q != WIDTH_SAT) begin
        width_d = width_q + CW'(1);
      end else begin
        width_d = width_q;
      end
    end else begin
      width_d = '0;
    end
    if (sync_prev_q && !sync_q) begin
      fall_class_d = (width_q >= WIDTH_SAT) ? SYNC_VSYNC : SYNC_HSYNC;
    end else begin
      fall_class_d = SYNC_NONE;
    end
  end

  // The pixel is delayed one extra stage so it lines up with the edge pulses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q       <= 1'b0;
      sync_prev_q  <= 1'b0;
      pix_q        <= 1'b0;
      pix_dly_q    <= 1'b0;
      width_q      <= '0;
      rise_q       <= 1'b0;
      fall_class_q <= SYNC_NONE;
    end else begin
      sync_q       <= sync_i;
      sync_prev_q  <= sync_q;
      pix_q        <= pix_i;
      pix_dly_q    <= pix_q;
      width_q      <= width_d;
      rise_q       <= rise_d;
      fall_class_q <= fall_class_d;
    end
  end

  assign fall_class_o = fall_class_q;
  assign rise_o       = rise_q;
  assign pix_o        = pix_dly_q;

endmodule

// File: rtl/video_capture.sv
// Capture FSM and pixel packer: rebuilds a 1-bpp frame from the composite
// sync/pixel stream as byte writes, with frame-done and timing-error pulses.
`timescale 1ns/1ps
module video_capture
  import video_capture_pkg::*;
#(
  parameter int unsigned CLKS_PER_PIXEL = 2,
  parameter int unsigned H_BACKPORCH    = 16,
  parameter int unsigned PIX_W          = 64,
  parameter int unsigned LINES          = 64,
  parameter int unsigned V_BACKPORCH    = 4,
  parameter int unsigned VSYNC_MIN      = 32,
  parameter int unsigned ADDR_W         = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              videoSync,
  input  logic              videoPixel,
  output logic              wrStrobe,
  output logic [ADDR_W-1:0] wrAddr,
  output logic [7:0]        wrData,
  output logic              frameDone,
  output logic              lineErr,
  output logic              frameErr,
  output logic              capturing
);

  localparam int unsigned BYTES_PER_LINE = PIX_W / 8;
  localparam int unsigned LW = $clog2(LINES + 1);
  localparam int unsigned PW = $clog2(PIX_W);
  localparam int unsigned HW = $clog2(V_BACKPORCH + 2);
  localparam int unsigned BW = $clog2(H_BACKPORCH + 1);
  localparam int unsigned CW = $clog2(CLKS_PER_PIXEL);
  localparam logic [LW-1:0] LINE_LAST    = LW'(LINES - 1);
  localparam logic [PW-1:0] PIX_LAST     = PW'(PIX_W - 1);
  localparam logic [HW-1:0] HCNT_LAST    = HW'(V_BACKPORCH - 1);
  localparam logic [BW-1:0] BP_LAST      = BW'(H_BACKPORCH - 1);
  localparam logic [CW-1:0] PHASE_LAST   = CW'(CLKS_PER_PIXEL - 1);
  localparam logic [CW-1:0] SAMPLE_PHASE = CW'(CLKS_PER_PIXEL / 2);

  sync_class_e fall_class_s;
  logic        rise_s, pix_s;

  cap_state_e        state_q, state_d;
  logic [LW-1:0]     line_q, line_d;
  logic [HW-1:0]     hcnt_q, hcnt_d;
  logic [BW-1:0]     bp_q, bp_d;
  logic [CW-1:0]     phase_q, phase_d;
  logic [PW-1:0]     pix_cnt_q, pix_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              wr_strobe_q, wr_strobe_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              done_pend_q, done_pend_d;
  logic              frame_done_q, frame_done_d;
  logic              line_err_q, line_err_d;
  logic              frame_err_q, frame_err_d;
  logic              capturing_q, capturing_d;

  video_sync_classifier #(
    .VSYNC_MIN (VSYNC_MIN)
  ) u_sync (
    .clk_i        (clk),
    .rst_i        (reset),
    .sync_i       (videoSync),
    .pix_i        (videoPixel),
    .fall_class_o (fall_class_s),
    .rise_o       (rise_s),
    .pix_o        (pix_s)
  );

  // Next-state logic; a vsync overrides whatever the line logic decided.
  always_comb begin
    state_d      = state_q;
    line_d       = line_q;
    hcnt_d       = hcnt_q;
    bp_d         = bp_q;
    phase_d      = phase_q;
    pix_cnt_d    = pix_cnt_q;
    shift_d      = shift_q;
    wr_strobe_d  = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    done_pend_d  = 1'b0;
    frame_done_d = done_pend_q;
    line_err_d   = 1'b0;
    frame_err_d  = 1'b0;

    case (state_q)
      ST_WAIT_VSYNC: begin
        state_d = ST_WAIT_VSYNC;
      end
      ST_VPORCH: begin
        if (fall_class_s == SYNC_HSYNC) begin
          if (hcnt_q == HCNT_LAST) begin
            state_d = ST_BACKPORCH;
            bp_d    = BW'(1);
          end else begin
            hcnt_d = hcnt_q + HW'(1);
          end
        end else begin
          hcnt_d = hcnt_q;
        end
      end
      ST_WAIT_LINE: begin
        if (fall_class_s == SYNC_HSYNC) begin
          state_d = ST_BACKPORCH;
          bp_d    = BW'(1);
        end else begin
          state_d = ST_WAIT_LINE;
        end
      end
      ST_BACKPORCH, ST_ACTIVE: begin
        // Sync rising mid-line: drop the partial byte, keep the line number.
        if (rise_s) begin
          line_err_d = 1'b1;
          state_d    = ST_WAIT_LINE;
          shift_d    = '0;
        end else if (state_q == ST_BACKPORCH) begin
          if (bp_q == BP_LAST) begin
            state_d   = ST_ACTIVE;
            phase_d   = '0;
            pix_cnt_d = '0;
            shift_d   = '0;
          end else begin
            bp_d = bp_q + BW'(1);
          end
        end else begin
          phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + CW'(1);
          if (phase_q == SAMPLE_PHASE) begin
            shift_d   = {shift_q[6:0], pix_s};
            pix_cnt_d = pix_cnt_q + PW'(1);
            if (pix_cnt_q[2:0] == 3'd7) begin
              wr_strobe_d = 1'b1;
              wr_data_d   = shift_d;
              wr_addr_d   = ADDR_W'(byte_addr(32'(line_q), 32'(pix_cnt_q >> 3),
                                              BYTES_PER_LINE));
            end else begin
              wr_strobe_d = 1'b0;
            end
            if (pix_cnt_q == PIX_LAST) begin
              line_d = line_q + LW'(1);
              if (line_q == LINE_LAST) begin
                done_pend_d = 1'b1;
                state_d     = ST_WAIT_VSYNC;
              end else begin
                state_d = ST_WAIT_LINE;
              end
            end else begin
              line_d = line_q;
            end
          end else begin
            shift_d = shift_q;
          end
        end
      end
      default: begin
        state_d = ST_WAIT_VSYNC;
      end
    endcase

    if (fall_class_s == SYNC_VSYNC) begin
      frame_err_d = (state_q != ST_WAIT_VSYNC);
      state_d     = (V_BACKPORCH == 0) ? ST_WAIT_LINE : ST_VPORCH;
      line_d      = '0;
      hcnt_d      = '0;
    end else begin
      frame_err_d = 1'b0;
    end

    capturing_d = (state_d == ST_BACKPORCH) || (state_d == ST_ACTIVE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_WAIT_VSYNC;
      line_q       <= '0;
      hcnt_q       <= '0;
      bp_q         <= '0;
      phase_q      <= '0;
      pix_cnt_q    <= '0;
      shift_q      <= '0;
      wr_strobe_q  <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      done_pend_q  <= 1'b0;
      frame_done_q <= 1'b0;
      line_err_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      capturing_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      line_q       <= line_d;
      hcnt_q       <= hcnt_d;
      bp_q         <= bp_d;
      phase_q      <= phase_d;
      pix_cnt_q    <= pix_cnt_d;
      shift_q      <= shift_d;
      wr_strobe_q  <= wr_strobe_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      done_pend_q  <= done_pend_d;
      frame_done_q <= frame_done_d;
      line_err_q   <= line_err_d;
      frame_err_q  <= frame_err_d;
      capturing_q  <= capturing_d;
    end
  end

  assign wrStrobe  = wr_strobe_q;
  assign wrAddr    = wr_addr_q;
  assign wrData    = wr_data_q;
  assign frameDone = frame_done_q;
  assign lineErr   = line_err_q;
  assign frameErr  = frame_err_q;
  assign capturing = capturing_q;

endmodule
